// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage
// ----------------
// Generic pipeline stage register with a valid/ready handshake and a
// two-entry skid buffer. It can sit between any two pipeline stages. The
// control field is replaced by a bubble value on flush or when the stage is
// empty. The data field is never rewritten by a flush.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   flush      in   kill all held entries (branch/jump redirect)
//   in_valid   in   upstream entry present
//   in_ready   out  stage can accept (registered)
//   in_ctrl    in   upstream control field   [CTRL_W]
//   in_data    in   upstream payload         [DATA_W]
//   out_valid  out  output entry present
//   out_ready  in   downstream accepts
//   out_ctrl   out  output control field     [CTRL_W]
//   out_data   out  output payload           [DATA_W]
//   occupancy  out  entries held (0..2)
//   stall_cnt  out  saturating count of back-pressured cycles [CNT_W]
module id_ex_skid_stage #(
   parameter int                CTRL_W      = 8,
   parameter int                DATA_W      = 128,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
   parameter int                CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic                in_ready_reg;
   logic [CTRL_W-1:0]   main_ctrl_reg;
   logic [DATA_W-1:0]   main_data_reg;
   logic [CTRL_W-1:0]   skid_ctrl_reg;
   logic [DATA_W-1:0]   skid_data_reg;
   logic [CNT_W-1:0]    stall_cnt_reg;

   logic in_fire;
   logic out_fire;
   logic load_main;
   logic load_skid;
   logic main_from_skid;

   assign out_valid = (state_reg != EMPTY);
   assign in_fire   = in_valid & in_ready_reg;
   assign out_fire  = out_valid & out_ready;

   // Next-state and load decisions. Flush overrides everything: an in-fire
   // in the flush cycle is dropped, while an out-fire is left to the
   // downstream stage, which has already seen valid & ready.
   always_comb begin
      state_next     = state_reg;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_fire) begin
                  load_main  = 1'b1;
                  state_next = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
               end else if (in_fire) begin
                  load_skid  = 1'b1;
                  state_next = FULL;
               end else if (out_fire) begin
                  state_next = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so no in-fire can happen.
               if (out_fire) begin
                  main_from_skid = 1'b1;
                  state_next     = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= EMPTY;
         in_ready_reg  <= 1'b1;
         main_ctrl_reg <= CTRL_BUBBLE;
         main_data_reg <= '0;
         skid_ctrl_reg <= CTRL_BUBBLE;
         skid_data_reg <= '0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         // Registered ready: no combinational path from out_ready upstream.
         in_ready_reg <= (state_next != FULL);

         if (flush) begin
            main_ctrl_reg <= CTRL_BUBBLE;
            skid_ctrl_reg <= CTRL_BUBBLE;
         end else begin
            if (load_main) begin
               main_ctrl_reg <= in_ctrl;
               main_data_reg <= in_data;
            end else if (main_from_skid) begin
               main_ctrl_reg <= skid_ctrl_reg;
               main_data_reg <= skid_data_reg;
            end
            if (load_skid) begin
               skid_ctrl_reg <= in_ctrl;
               skid_data_reg <= in_data;
            end
         end

         // Saturating back-pressure counter; deliberately unaffected by flush.
         if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_ctrl  = out_valid ? main_ctrl_reg : CTRL_BUBBLE;
   assign out_data  = main_data_reg;
   assign stall_cnt = stall_cnt_reg;
   assign occupancy = (state_reg == FULL) ? 2'd2 :
                      (state_reg == ONE)  ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Testbench for id_ex_skid_stage: directed scenarios plus a random run, with a
// scoreboard queue filled by the stimulus task and drained by a monitor.
module tb_id_ex_skid_stage;

   localparam int        CTRL_W = 8;
   localparam int        DATA_W = 32;
   localparam logic [7:0] BUB   = 8'hA5;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic [15:0]       stall_cnt;

   // Second instance with a 4-bit counter for the saturation check.
   logic              in_ready4;
   logic              out_valid4;
   logic [CTRL_W-1:0] out_ctrl4;
   logic [DATA_W-1:0] out_data4;
   logic [1:0]        occupancy4;
   logic [3:0]        stall_cnt4;

   id_ex_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(BUB), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   id_ex_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(BUB), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_data(out_data4),
      .occupancy(occupancy4), .stall_cnt(stall_cnt4)
   );

   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } entry_t;

   entry_t exp_q[$];
   int     checks = 0;
   int     errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus. Called at posedge+1; returns at the next
   // posedge+1. The scoreboard is updated at the edge where the handshake
   // takes effect, after the monitor has sampled the preceding negedge.
   task automatic cycle(input logic iv, input logic [7:0] c, input logic [31:0] d,
                        input logic ordy, input logic fl);
      logic fire;
      in_valid  = iv;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      fire = iv & in_ready;
      @(posedge clk);
      if (fl) exp_q.delete();
      else if (fire) exp_q.push_back('{c: c, d: d});
      #1;
   endtask

   // Monitor: every delivered entry must match the head of the scoreboard;
   // an idle stage must present the bubble control value.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got ctrl=%02h data=%08h expected no entry", out_ctrl, out_data);
            end else begin
               entry_t e;
               e = exp_q.pop_front();
               $display("out ctrl=%02h data=%08h", out_ctrl, out_data);
               chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
               chk("out_data", 64'(out_data), 64'(e.d));
            end
         end else if (!out_valid) begin
            chk("bubble_ctrl", 64'(out_ctrl), 64'(BUB));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 0; in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0;
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_occ",       64'(occupancy), 64'd0);
      chk("rst_out_ctrl",  64'(out_ctrl),  64'(BUB));
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_stall",     64'(stall_cnt), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Streaming with out_ready held high.
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 8'(i), 32'(i), 1'b1, 1'b0);
         chk("stream_valid", 64'(out_valid), 64'd1);
         chk("stream_data",  64'(out_data),  64'(i));
         chk("stream_occ",   64'(occupancy), 64'd1);
         chk("stream_ready", 64'(in_ready),  64'd1);
      end
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      chk("stream_occ_end", 64'(occupancy), 64'd0);
      chk("stream_stall",   64'(stall_cnt), 64'd0);

      // Stall counter and saturation.
      cycle(1'b1, 8'h11, 32'h0000AAAA, 1'b0, 1'b0);
      repeat (10) cycle(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
      chk("stall_10",   64'(stall_cnt),  64'd10);
      chk("stall4_10",  64'(stall_cnt4), 64'd10);
      repeat (10) cycle(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
      chk("stall_20",   64'(stall_cnt),  64'd20);
      chk("stall4_sat", 64'(stall_cnt4), 64'd15);
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      chk("stall_hold", 64'(stall_cnt), 64'd20);
      chk("stall_drain_occ", 64'(occupancy), 64'd0);

      // Skid fill and drain.
      cycle(1'b1, 8'h0A, 32'h000000A0, 1'b0, 1'b0);
      chk("skid_ready1", 64'(in_ready), 64'd1);
      cycle(1'b1, 8'h0B, 32'h000000B0, 1'b0, 1'b0);
      chk("skid_occ2",   64'(occupancy), 64'd2);
      chk("skid_ready0", 64'(in_ready),  64'd0);
      chk("skid_data_a", 64'(out_data),  64'h000000A0);
      cycle(1'b1, 8'h0C, 32'h000000C0, 1'b0, 1'b0); // refused: stage full
      chk("skid_occ_hold", 64'(occupancy), 64'd2);
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      chk("skid_occ1",   64'(occupancy), 64'd1);
      chk("skid_ready1b", 64'(in_ready), 64'd1);
      chk("skid_data_b", 64'(out_data),  64'h000000B0);
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      chk("skid_occ0",   64'(occupancy), 64'd0);

      // Flush while full with a new entry offered in the same cycle.
      cycle(1'b1, 8'h21, 32'h00000021, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 32'h00000022, 1'b0, 1'b0);
      chk("fl_full", 64'(occupancy), 64'd2);
      cycle(1'b1, 8'h23, 32'h00000023, 1'b0, 1'b1);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_ctrl",  64'(out_ctrl),  64'(BUB));
      chk("fl_occ",   64'(occupancy), 64'd0);
      chk("fl_ready", 64'(in_ready),  64'd1);
      repeat (3) cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      chk("fl_still_empty", 64'(out_valid), 64'd0);

      // Flush coinciding with an out-fire: the entry is still delivered.
      cycle(1'b1, 8'h31, 32'h00000031, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
      chk("flof_occ", 64'(occupancy), 64'd0);

      // Asynchronous reset while full.
      cycle(1'b1, 8'h41, 32'h00000041, 1'b0, 1'b0);
      cycle(1'b1, 8'h42, 32'h00000042, 1'b0, 1'b0);
      chk("ar_full", 64'(occupancy), 64'd2);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_ready", 64'(in_ready),  64'd1);
      chk("ar_occ",   64'(occupancy), 64'd0);
      chk("ar_ctrl",  64'(out_ctrl),  64'(BUB));
      chk("ar_data",  64'(out_data),  64'd0);
      chk("ar_stall", 64'(stall_cnt), 64'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      cycle(1'b1, 8'h51, 32'h00000051, 1'b1, 1'b0);
      chk("ar_first_valid", 64'(out_valid), 64'd1);
      chk("ar_first_data",  64'(out_data),  64'h00000051);
      cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

      // Random traffic with sparse flushes.
      for (int k = 0; k < 4000; k++) begin
         cycle(($urandom_range(0, 1) == 1), 8'($urandom), 32'(32'h1000 + k),
               ($urandom_range(0, 4) < 3), ($urandom_range(0, 63) == 0));
      end
      for (int k = 0; k < 10 && (exp_q.size() != 0 || out_valid); k++)
         cycle(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
      chk("drain_queue", 64'(exp_q.size()), 64'd0);
      chk("drain_valid", 64'(out_valid),    64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
